// File: rtl/display_pkg.sv
// Shared definitions for the ALU result display stage.
//
// Contents:
//   state_t      conversion controller states
//   SEG_DIGIT    active-low seven-segment codes for 0..9 (bit0 = a ... bit6 = g)
//   SEG_BLANK    all segments off
//   SEG_MINUS    only segment g lit
//   ANODE_OFF    all digit enables inactive
//   BCD_W        width of the three-digit BCD result
//   digit_segs() BCD nibble to segment code; out-of-range nibbles blank
//   add3_ge5()   double-dabble nibble correction
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam int         BCD_W     = 12;

  function automatic logic [6:0] digit_segs(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_DIGIT[0];
      4'd1:    return SEG_DIGIT[1];
      4'd2:    return SEG_DIGIT[2];
      4'd3:    return SEG_DIGIT[3];
      4'd4:    return SEG_DIGIT[4];
      4'd5:    return SEG_DIGIT[5];
      4'd6:    return SEG_DIGIT[6];
      4'd7:    return SEG_DIGIT[7];
      4'd8:    return SEG_DIGIT[8];
      4'd9:    return SEG_DIGIT[9];
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3_ge5(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
//
// A start pulse captures the operand, resolves sign/magnitude and clears the
// BCD register; the following DATA_W cycles each correct and shift one
// magnitude bit in. done is high during the final shift cycle, so the BCD
// output is complete on the cycle after done.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-high reset (iteration counter only)
//   start        load operand and begin conversion
//   value        operand
//   signed_mode  1 = operand is two's complement
//   done         last shift happens this cycle
//   neg          operand was negative
//   bcd          hundreds[11:8], tens[7:4], units[3:0]
module bin_to_bcd_seq
  import display_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  input  logic              signed_mode,
  output logic              done,
  output logic              neg,
  output logic [BCD_W-1:0]  bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic        [CNT_W-1:0]  iter;
  logic signed [DATA_W-1:0] value_s;
  logic                     neg_in;
  logic        [DATA_W-1:0] mag_in;
  logic        [DATA_W-1:0] mag_sr;
  logic        [BCD_W-1:0]  bcd_sr;
  logic        [BCD_W-1:0]  bcd_adj;
  logic                     neg_r;

  // Negating the most negative value wraps to itself, which read as unsigned
  // is exactly its magnitude (0x80 -> 128).
  assign value_s = value;
  assign neg_in  = signed_mode && (value_s < 0);
  assign mag_in  = neg_in ? DATA_W'(-value_s) : value;

  assign bcd_adj = {add3_ge5(bcd_sr[11:8]), add3_ge5(bcd_sr[7:4]), add3_ge5(bcd_sr[3:0])};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iter <= '0;
    end else if (start) begin
      iter <= CNT_W'(DATA_W);
    end else if (iter != '0) begin
      iter <= iter - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      neg_r  <= neg_in;
      mag_sr <= mag_in;
      bcd_sr <= '0;
    end else if (iter != '0) begin
      bcd_sr <= (bcd_adj << 1) | BCD_W'(mag_sr[DATA_W-1]);
      mag_sr <= mag_sr << 1;
    end
  end

  assign done = (iter == CNT_W'(1));
  assign neg  = neg_r;
  assign bcd  = bcd_sr;

endmodule

// File: rtl/result_display.sv
// ALU result display stage: converts the result to decimal and drives a
// 4-digit multiplexed seven-segment display.
//
// A strobe starts a conversion (LOAD, 8 x SHIFT, COMMIT). Strobes arriving
// while busy are held in a single pending slot, newest wins, and are started
// straight from COMMIT. Display registers only change in COMMIT so a digit
// is never shown half-converted. Scanning runs independently of conversion.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-high reset
//   y_in         ALU result
//   y_valid      one-cycle strobe qualifying y_in
//   signed_mode  1 = y_in is two's complement
//   anode        active-low digit enables (0 = units ... 3 = sign)
//   segs         active-low segments (bit0 = a ... bit6 = g)
//   busy         conversion in progress
module result_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DATA_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] y_in,
  input  logic              y_valid,
  input  logic              signed_mode,
  output logic [3:0]        anode,
  output logic [6:0]        segs,
  output logic              busy
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t state, state_next;

  logic [DATA_W-1:0] cur_y;
  logic              cur_sm;
  logic [DATA_W-1:0] pend_y;
  logic              pend_sm;
  logic              pending;

  logic              start;
  logic              commit;
  logic              take_input;
  logic              take_pending;
  logic              pend_set;

  logic              conv_done;
  logic              conv_neg;
  logic [BCD_W-1:0]  conv_bcd;

  logic [3:0]        disp_h;
  logic [3:0]        disp_t;
  logic [3:0]        disp_u;
  logic              disp_neg;

  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_wrap;
  logic [1:0]        idx;
  logic [1:0]        idx_next;
  logic [6:0]        seg_next;

  bin_to_bcd_seq #(
    .DATA_W (DATA_W)
  ) u_conv (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .value       (cur_y),
    .signed_mode (cur_sm),
    .done        (conv_done),
    .neg         (conv_neg),
    .bcd         (conv_bcd)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A strobe landing in COMMIT behaves as if it had been pending, and being
  // newer it supersedes whatever the pending slot holds.
  always_comb begin
    state_next   = state;
    start        = 1'b0;
    commit       = 1'b0;
    take_input   = 1'b0;
    take_pending = 1'b0;
    pend_set     = 1'b0;
    case (state)
      IDLE: begin
        if (y_valid) begin
          take_input = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        start      = 1'b1;
        pend_set   = y_valid;
        state_next = SHIFT;
      end
      SHIFT: begin
        pend_set = y_valid;
        if (conv_done) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        commit = 1'b1;
        if (y_valid) begin
          take_input = 1'b1;
          state_next = LOAD;
        end else if (pending) begin
          take_pending = 1'b1;
          state_next   = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (pend_set) begin
      pending <= 1'b1;
    end else if (commit) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (pend_set) begin
      pend_y  <= y_in;
      pend_sm <= signed_mode;
    end
  end

  always_ff @(posedge clock) begin
    if (take_input) begin
      cur_y  <= y_in;
      cur_sm <= signed_mode;
    end else if (take_pending) begin
      cur_y  <= pend_y;
      cur_sm <= pend_sm;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_h   <= 4'd0;
      disp_t   <= 4'd0;
      disp_u   <= 4'd0;
      disp_neg <= 1'b0;
    end else if (commit) begin
      disp_h   <= conv_bcd[11:8];
      disp_t   <= conv_bcd[7:4];
      disp_u   <= conv_bcd[3:0];
      disp_neg <= conv_neg;
    end
  end

  // Leading-zero blanking: tens only blank when hundreds is blank as well.
  always_comb begin
    seg_next = SEG_BLANK;
    case (idx_next)
      2'd0: seg_next = digit_segs(disp_u);
      2'd1: seg_next = ((disp_h == 4'd0) && (disp_t == 4'd0)) ? SEG_BLANK : digit_segs(disp_t);
      2'd2: seg_next = (disp_h == 4'd0) ? SEG_BLANK : digit_segs(disp_h);
      2'd3: seg_next = disp_neg ? SEG_MINUS : SEG_BLANK;
      default: seg_next = SEG_BLANK;
    endcase
  end

  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign idx_next  = scan_wrap ? (idx + 2'd1) : idx;

  // anode and segs are both registered from the upcoming index so they
  // switch on the same edge and no digit briefly shows its neighbour.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      anode    <= 4'b1110;
      segs     <= SEG_DIGIT[0];
    end else begin
      scan_cnt <= scan_wrap ? '0 : (scan_cnt + 1'b1);
      idx      <= idx_next;
      anode    <= ANODE_OFF ^ (4'b0001 << idx_next);
      segs     <= seg_next;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Testbench for result_display (SCAN_DIV = 4): directed table, multi-cycle
// sequences and randomized vectors against a decimal reference model.
module tb_result_display;

  localparam int SCAN_DIV = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] y_in;
  logic       y_valid;
  logic       signed_mode;
  logic [3:0] anode;
  logic [6:0] segs;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  result_display #(
    .SCAN_DIV (SCAN_DIV),
    .DATA_W   (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .y_in        (y_in),
    .y_valid     (y_valid),
    .signed_mode (signed_mode),
    .anode       (anode),
    .segs        (segs),
    .busy        (busy)
  );

  typedef struct {
    logic [7:0] y;
    logic       sm;
    int         value;
  } vec_t;

  // Reference: numeric value shown for an input, then segment code per digit.
  function automatic int model_value(logic [7:0] y, logic sm);
    if (sm && y[7]) return int'(y) - 256;
    return int'(y);
  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int v, int pos);
    int mag, h, t, u;
    mag = (v < 0) ? -v : v;
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    case (pos)
      0: return seg_of(u);
      1: return (h == 0 && t == 0) ? 7'h7F : seg_of(t);
      2: return (h == 0) ? 7'h7F : seg_of(h);
      default: return (v < 0) ? 7'h3F : 7'h7F;
    endcase
  endfunction

  function automatic int anode_idx(logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_digit(input string name, input int v);
    int p;
    p = anode_idx(anode);
    if (p < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_anode actual=%b required=one-hot-low", name, anode);
    end else begin
      check(name, {25'd0, segs}, {25'd0, exp_seg(v, p)});
    end
  endtask

  task automatic scan_check(input string name, input int v);
    repeat (4 * SCAN_DIV) begin
      tick();
      check_digit(name, v);
    end
  endtask

  task automatic strobe(input logic [7:0] y, input logic sm);
    y_in        = y;
    signed_mode = sm;
    y_valid     = 1'b1;
    tick();
    y_valid     = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hFF, 1'b0, 255};
    vecs[1] = '{8'h80, 1'b1, -128};
    vecs[2] = '{8'hF6, 1'b1, -10};
    vecs[3] = '{8'h07, 1'b0, 7};
    vecs[4] = '{8'h00, 1'b0, 0};
    vecs[5] = '{8'h80, 1'b0, 128};
    vecs[6] = '{8'h7F, 1'b1, 127};

    reset       = 1'b1;
    y_valid     = 1'b0;
    y_in        = 8'h00;
    signed_mode = 1'b0;

    // Reset state and first scan step.
    repeat (3) tick();
    check("rst_anode", {28'd0, anode}, 32'hE);
    check("rst_segs", {25'd0, segs}, 32'h40);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("scan_hold_anode", {28'd0, anode}, 32'hE);
    tick();
    check("scan_step_anode", {28'd0, anode}, 32'hD);
    check("scan_step_segs", {25'd0, segs}, 32'h7F);

    // Busy covers exactly the ten conversion cycles.
    strobe(8'hFF, 1'b0);
    check("busy_c1", {31'd0, busy}, 32'd1);
    for (int i = 2; i <= 10; i++) begin
      tick();
      check("busy_c2_10", {31'd0, busy}, 32'd1);
    end
    tick();
    check("busy_c11", {31'd0, busy}, 32'd0);
    scan_check("disp_255", 255);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      strobe(vecs[i].y, vecs[i].sm);
      wait_idle("tbl_idle");
      scan_check($sformatf("tbl_%0d", i), vecs[i].value);
    end

    // Strobes while busy: 0x22 is overwritten by 0x63 before it can start.
    for (int c = 0; c <= 20; c++) begin
      y_valid     = (c == 0 || c == 3 || c == 5);
      y_in        = (c == 0) ? 8'h0C : ((c == 3) ? 8'h22 : 8'h63);
      signed_mode = 1'b0;
      tick();
      check("pend_busy", {31'd0, busy}, {31'd0, (c <= 19)});
      if (c >= 11) check_digit("pend_12", 12);
    end
    y_valid = 1'b0;
    scan_check("pend_99", 99);

    // Reset in the middle of a conversion.
    strobe(8'hFF, 1'b0);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_anode", {28'd0, anode}, 32'hE);
    check("midrst_segs", {25'd0, segs}, 32'h40);
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("midrst_idle", {31'd0, busy}, 32'd0);
    end
    scan_check("midrst_disp0", 0);

    // Random single conversions.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] ry;
      logic       rs;
      ry = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      strobe(ry, rs);
      wait_idle("rnd_idle");
      scan_check("rnd_disp", model_value(ry, rs));
    end

    // Random back-to-back: a second strobe during the first conversion.
    for (int n = 0; n < 6; n++) begin
      logic [7:0] ya, yb;
      logic       sa, sb;
      int         k;
      ya = 8'($urandom_range(0, 255));
      yb = 8'($urandom_range(0, 255));
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(1, 9));
      strobe(ya, sa);
      repeat (k - 1) tick();
      strobe(yb, sb);
      wait_idle("b2b_idle");
      scan_check("b2b_disp", model_value(yb, sb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
